microseq_control: RTL and testbench

- Parametrised LC-3b microsequenced control unit; successor to the fixed FSM + control-store controller.
- Holds the microstate register and an internal control store, and computes the next state. Next-state logic uses IRD opcode dispatch, COND-based branching (memory ready, BEN, IR[11]) and the J field.
- Adds a BEN register, a memory-ready timeout with a terminal fault state, and flagging of illegal opcodes.
- Drives the datapath load enables, ALU op and memory controls; sits between the datapath (IR, N/Z/P) and memory (R).

---
 rtl/microseq_control_if.sv | 38 +++
 rtl/microseq_control.sv | 180 ++++++++++++++++++
 tb/tb_microseq_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/microseq_control_if.sv
// Bus between the LC-3b microsequencer and its datapath/memory neighbours:
// instruction and condition-code inputs, memory ready, and all control outputs.
interface microseq_control_if #(
    parameter int STATE_W = 6,
    parameter int ALUOP_W = 3
);
    logic [15:0]        IR;
    logic               N;
    logic               Z;
    logic               P;
    logic               R;
    logic [ALUOP_W-1:0] aluop;
    logic               LDCC;
    logic               LDIR;
    logic               LDREG;
    logic               LDPC;
    logic               LDMAR;
    logic               LDMDR;
    logic               MEMEN;
    logic               MEMRW;
    logic [STATE_W-1:0] state;
    logic               illegal;
    logic               fault;

    // Controller side: consumes IR/condition codes/ready, drives controls.
    modport master (
        input  IR, N, Z, P, R,
        output aluop, LDCC, LDIR, LDREG, LDPC, LDMAR, LDMDR, MEMEN, MEMRW,
        output state, illegal, fault
    );

    // Datapath/memory side: the mirror image of the controller view.
    modport slave (
        output IR, N, Z, P, R,
        input  aluop, LDCC, LDIR, LDREG, LDPC, LDMAR, LDMDR, MEMEN, MEMRW,
        input  state, illegal, fault
    );
endinterface

// File: rtl/microseq_control.sv
// LC-3b microsequenced control unit. A registered microinstruction (the
// control-store word of the current state) drives the datapath controls and
// feeds the next-state logic: IRD opcode dispatch, COND branching on BEN,
// memory ready or IR[11], and the J field. Adds a BEN register, a
// memory-wait timeout into a terminal fault state, and illegal-opcode flagging.
module microseq_control #(
    parameter int STATE_W     = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int FAULT_STATE = 63
) (
    input  logic               clk,
    input  logic               reset,
    microseq_control_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_BR       = STATE_W'(0),
        S_ADD      = STATE_W'(1),
        S_AND      = STATE_W'(5),
        S_LDW      = STATE_W'(6),
        S_STW      = STATE_W'(7),
        S_NOT      = STATE_W'(9),
        S_STW_WR   = STATE_W'(16),
        S_FETCH    = STATE_W'(18),
        S_BR_TAKEN = STATE_W'(22),
        S_STW_MDR  = STATE_W'(23),
        S_LDW_RD   = STATE_W'(25),
        S_LDW_WB   = STATE_W'(27),
        S_DECODE   = STATE_W'(32),
        S_FETCH_RD = STATE_W'(33),
        S_FETCH_IR = STATE_W'(35)
    } state_t;

    localparam state_t FAULT_S = state_t'(FAULT_STATE);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_NOT   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_PASSA = ALUOP_W'(3);

    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_R    = 2'b01;
    localparam logic [1:0] COND_BEN  = 2'b10;
    localparam logic [1:0] COND_IR11 = 2'b11;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef struct packed {
        logic               ird;
        logic [1:0]         cond;
        logic [5:0]         j;
        logic               ldben;
        logic [ALUOP_W-1:0] aluop;
        logic               ldcc;
        logic               ldir;
        logic               ldreg;
        logic               ldpc;
        logic               ldmar;
        logic               ldmdr;
        logic               memen;
        logic               memrw;
    } uinst_t;

    // Control store. Anything without an entry (including FAULT_STATE) reads
    // as the default word: no controls asserted, J=18.
    function automatic uinst_t ucode(input state_t s);
        uinst_t u;
        u      = '0;
        u.cond = COND_NONE;
        u.j    = 6'd18;
        case (s)
            S_FETCH:    begin u.ldmar = 1'b1; u.ldpc = 1'b1; u.j = 6'd33; end
            S_FETCH_RD: begin u.memen = 1'b1; u.ldmdr = 1'b1; u.cond = COND_R; u.j = 6'd33; end
            S_FETCH_IR: begin u.ldir = 1'b1; u.j = 6'd32; end
            S_DECODE:   begin u.ird = 1'b1; u.ldben = 1'b1; end
            S_ADD:      begin u.ldreg = 1'b1; u.ldcc = 1'b1; u.aluop = ALU_ADD; end
            S_AND:      begin u.ldreg = 1'b1; u.ldcc = 1'b1; u.aluop = ALU_AND; end
            S_NOT:      begin u.ldreg = 1'b1; u.ldcc = 1'b1; u.aluop = ALU_NOT; end
            S_BR:       begin u.cond = COND_BEN; end
            S_BR_TAKEN: begin u.ldpc = 1'b1; end
            S_LDW:      begin u.ldmar = 1'b1; u.j = 6'd25; end
            S_LDW_RD:   begin u.memen = 1'b1; u.ldmdr = 1'b1; u.cond = COND_R; u.j = 6'd25; end
            S_LDW_WB:   begin u.ldreg = 1'b1; u.ldcc = 1'b1; u.aluop = ALU_PASSA; end
            S_STW:      begin u.ldmar = 1'b1; u.j = 6'd23; end
            S_STW_MDR:  begin u.ldmdr = 1'b1; u.aluop = ALU_PASSA; u.j = 6'd16; end
            S_STW_WR:   begin u.memen = 1'b1; u.memrw = 1'b1; u.cond = COND_R; u.j = 6'd16; end
            default:    ;
        endcase
        return u;
    endfunction

    // States that have a control-store entry; an IRD dispatch to anything else is illegal.
    function automatic logic has_entry(input state_t s);
        case (s)
            S_FETCH, S_FETCH_RD, S_FETCH_IR, S_DECODE, S_ADD, S_AND, S_NOT,
            S_BR, S_BR_TAKEN, S_LDW, S_LDW_RD, S_LDW_WB, S_STW, S_STW_MDR,
            S_STW_WR: has_entry = 1'b1;
            default:  has_entry = 1'b0;
        endcase
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    uinst_t           u_q;
    uinst_t           u_nxt;
    logic             ben_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ill_nxt;
    logic             illegal_q;
    logic             fault_q;
    logic             waiting;
    logic             tmo_hit;
    logic [2:0]       cond_bits;
    logic             unused_ir;

    assign unused_ir = ^bus.IR[8:0];

    // Next microstate, timeout detection and the control word to load with it.
    always_comb begin
        waiting   = (u_q.cond == COND_R) && !bus.R;
        tmo_hit   = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TO_LAST);
        cond_bits = {(u_q.cond == COND_BEN)  && ben_q,
                     (u_q.cond == COND_R)    && bus.R,
                     (u_q.cond == COND_IR11) && bus.IR[11]};
        if (state_q == FAULT_S || tmo_hit) begin
            state_nxt = FAULT_S;
        end else if (u_q.ird) begin
            state_nxt = state_t'(STATE_W'(bus.IR[15:12]));
        end else begin
            state_nxt = state_t'(STATE_W'(u_q.j | {3'b000, cond_bits}));
        end
        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if (waiting) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
            cnt_nxt = cnt_q;
        end
        u_nxt   = ucode(state_nxt);
        ill_nxt = u_q.ird && !has_entry(state_nxt);
    end

    // Microsequencer state machine: state, microinstruction, BEN, wait counter and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            u_q       <= ucode(S_FETCH);
            ben_q     <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            u_q       <= u_nxt;
            cnt_q     <= cnt_nxt;
            illegal_q <= ill_nxt;
            fault_q   <= (state_nxt == FAULT_S);
            if (u_q.ldben) begin
                ben_q <= (bus.IR[11] & bus.N) | (bus.IR[10] & bus.Z) | (bus.IR[9] & bus.P);
            end
        end
    end

    assign bus.state   = state_q;
    assign bus.aluop   = u_q.aluop;
    assign bus.LDCC    = u_q.ldcc;
    assign bus.LDIR    = u_q.ldir;
    assign bus.LDREG   = u_q.ldreg;
    assign bus.LDPC    = u_q.ldpc;
    assign bus.LDMAR   = u_q.ldmar;
    assign bus.LDMDR   = u_q.ldmdr;
    assign bus.MEMEN   = u_q.memen;
    assign bus.MEMRW   = u_q.memrw;
    assign bus.illegal = illegal_q;
    assign bus.fault   = fault_q;

endmodule

// File: tb/tb_microseq_control.sv
// Bench for microseq_control: two instances (timeout 16 and timeout 4) run the
// same directed and random stimulus against a state-graph reference model.
module tb_microseq_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    microseq_control_if #(.STATE_W(6), .ALUOP_W(3)) bus_a ();
    microseq_control_if #(.STATE_W(6), .ALUOP_W(3)) bus_b ();

    microseq_control #(.STATE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(16), .FAULT_STATE(63)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    microseq_control #(.STATE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(4), .FAULT_STATE(63)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct packed {
        logic [2:0] aluop;
        logic ldcc, ldir, ldreg, ldpc, ldmar, ldmdr, memen, memrw, fault;
    } ctl_t;

    int   errors = 0;
    int   checks = 0;
    int   m_state [2];
    int   m_wait  [2];
    logic m_ben   [2];
    logic m_ill   [2];
    int   tmo     [2] = '{16, 4};

    logic [5:0] obs_st  [2];
    ctl_t       obs_ctl [2];
    logic       obs_ill [2];

    assign obs_st[0]  = bus_a.state;
    assign obs_st[1]  = bus_b.state;
    assign obs_ill[0] = bus_a.illegal;
    assign obs_ill[1] = bus_b.illegal;
    assign obs_ctl[0] = {bus_a.aluop, bus_a.LDCC, bus_a.LDIR, bus_a.LDREG, bus_a.LDPC,
                         bus_a.LDMAR, bus_a.LDMDR, bus_a.MEMEN, bus_a.MEMRW, bus_a.fault};
    assign obs_ctl[1] = {bus_b.aluop, bus_b.LDCC, bus_b.LDIR, bus_b.LDREG, bus_b.LDPC,
                         bus_b.LDMAR, bus_b.LDMDR, bus_b.MEMEN, bus_b.MEMRW, bus_b.fault};

    // Expected controls in each microstate, straight from the microprogram table.
    function automatic ctl_t exp_ctl(input int s);
        ctl_t c;
        c = '0;
        case (s)
            18: begin c.ldmar = 1; c.ldpc = 1; end
            33: begin c.memen = 1; c.ldmdr = 1; end
            35: c.ldir = 1;
            1:  begin c.ldreg = 1; c.ldcc = 1; c.aluop = 3'd0; end
            5:  begin c.ldreg = 1; c.ldcc = 1; c.aluop = 3'd1; end
            9:  begin c.ldreg = 1; c.ldcc = 1; c.aluop = 3'd2; end
            22: c.ldpc = 1;
            6:  c.ldmar = 1;
            25: begin c.memen = 1; c.ldmdr = 1; end
            27: begin c.ldreg = 1; c.ldcc = 1; c.aluop = 3'd3; end
            7:  c.ldmar = 1;
            23: begin c.ldmdr = 1; c.aluop = 3'd3; end
            16: begin c.memen = 1; c.memrw = 1; end
            63: c.fault = 1;
            default: ;
        endcase
        return c;
    endfunction

    // Successor in the instruction-flow graph; 'waited' is cycles already spent in a wait state.
    function automatic int exp_next(input int s, input logic [15:0] ir, input logic ben,
                                    input logic r, input int waited, input int limit);
        int hold;
        hold = (limit != 0 && waited >= limit - 1) ? 63 : s;
        case (s)
            18: return 33;
            33: return r ? 35 : hold;
            35: return 32;
            32: return int'(ir[15:12]);
            0:  return ben ? 22 : 18;
            6:  return 25;
            25: return r ? 27 : hold;
            7:  return 23;
            23: return 16;
            16: return r ? 18 : hold;
            63: return 63;
            default: return 18;
        endcase
    endfunction

    task automatic compare(input int k, input string tag);
        checks++;
        assert (obs_st[k] === 6'(m_state[k])) else begin
            errors++;
            $error("FAIL %s dut%0d state: got %0d expected %0d", tag, k, obs_st[k], m_state[k]);
        end
        checks++;
        assert (obs_ctl[k] === exp_ctl(m_state[k])) else begin
            errors++;
            $error("FAIL %s dut%0d controls in state %0d: got %h expected %h",
                   tag, k, m_state[k], obs_ctl[k], exp_ctl(m_state[k]));
        end
        checks++;
        assert (obs_ill[k] === m_ill[k]) else begin
            errors++;
            $error("FAIL %s dut%0d illegal: got %b expected %b", tag, k, obs_ill[k], m_ill[k]);
        end
    endtask

    // One clock: apply inputs, advance the model on the same edge, then compare.
    task automatic step(input logic rst_i, input logic [15:0] ir_i, input logic r_i,
                        input logic [2:0] nzp, input string tag);
        int nx;
        reset    = rst_i;
        bus_a.IR = ir_i;   bus_b.IR = ir_i;
        bus_a.R  = r_i;    bus_b.R  = r_i;
        bus_a.N  = nzp[2]; bus_b.N  = nzp[2];
        bus_a.Z  = nzp[1]; bus_b.Z  = nzp[1];
        bus_a.P  = nzp[0]; bus_b.P  = nzp[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_i) begin
                m_state[k] = 18;
                m_ben[k]   = 1'b0;
                m_wait[k]  = 0;
                m_ill[k]   = 1'b0;
            end else begin
                nx       = exp_next(m_state[k], ir_i, m_ben[k], r_i, m_wait[k], tmo[k]);
                m_ill[k] = (m_state[k] == 32) && !(int'(ir_i[15:12]) inside {0, 1, 5, 6, 7, 9});
                if (m_state[k] == 32)
                    m_ben[k] = (ir_i[11] & nzp[2]) | (ir_i[10] & nzp[1]) | (ir_i[9] & nzp[0]);
                m_wait[k]  = (nx == m_state[k]) ? m_wait[k] + 1 : 0;
                m_state[k] = nx;
            end
            compare(k, tag);
        end
    endtask

    initial begin
        logic [15:0] ir_r;
        // Reset
        step(1'b1, 16'h0000, 1'b1, 3'b000, "reset");
        step(1'b1, 16'h0000, 1'b0, 3'b000, "reset_hold");
        // ADD: 18,33,35,32,1,18
        repeat (5) step(1'b0, 16'h1000, 1'b1, 3'b000, "add");
        // BR nzp with Z=1: taken through 22
        repeat (6) step(1'b0, 16'h0E00, 1'b1, 3'b010, "br_taken");
        // BR n only with Z=1: not taken
        repeat (5) step(1'b0, 16'h0800, 1'b1, 3'b010, "br_not_taken");
        // LDW with ready low three cycles in state 25; R=1 wins on the last limit cycle of dut1
        repeat (5) step(1'b0, 16'h6000, 1'b1, 3'b000, "ldw_fetch");
        repeat (3) step(1'b0, 16'h6000, 1'b0, 3'b000, "ldw_wait");
        repeat (2) step(1'b0, 16'h6000, 1'b1, 3'b000, "ldw_done");
        // STW: 7,23,16 then back to 18
        repeat (7) step(1'b0, 16'h7000, 1'b1, 3'b000, "stw");
        // Unimplemented opcode 13
        repeat (5) step(1'b0, 16'hD000, 1'b1, 3'b000, "illegal");
        // Memory never ready: both instances time out into the fault state
        step(1'b1, 16'h1000, 1'b0, 3'b000, "tmo_reset");
        repeat (22) step(1'b0, 16'h1000, 1'b0, 3'b000, "timeout");
        step(1'b0, 16'h1000, 1'b1, 3'b000, "fault_sticky");
        step(1'b1, 16'h1000, 1'b1, 3'b000, "fault_reset");
        // Random instruction mix with periodic resets
        for (int i = 0; i < 600; i++) begin
            ir_r = 16'($urandom);
            step((i % 50) == 49, ir_r, $urandom_range(0, 3) != 0, 3'($urandom), "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
